// File: rtl/wb_slave_arbiter_if.sv
// wb_slave_arbiter_if: Wishbone bundle linking NR_MASTERS masters, the arbiter and one shared slave
// Ports: none. Signals keep the arbiter's point of view:
//   m_*_i / m_*_o  master-side request and response lanes (master k at slice k)
//   s_*_o / s_*_i  slave-side request and response
// Modports: slave = the arbiter itself, master = the masters plus the slave model driving the other side
interface wb_slave_arbiter_if #(
   parameter int NR_MASTERS = 2
);
   logic [32*NR_MASTERS-1:0] m_adr_i;
   logic [32*NR_MASTERS-1:0] m_dat_i;
   logic [4*NR_MASTERS-1:0]  m_sel_i;
   logic [NR_MASTERS-1:0]    m_cyc_i;
   logic [NR_MASTERS-1:0]    m_stb_i;
   logic [NR_MASTERS-1:0]    m_we_i;
   logic [31:0]              m_dat_o;
   logic [NR_MASTERS-1:0]    m_ack_o;
   logic [NR_MASTERS-1:0]    m_err_o;
   logic [31:0]              s_adr_o;
   logic [31:0]              s_dat_o;
   logic [3:0]               s_sel_o;
   logic                     s_cyc_o;
   logic                     s_stb_o;
   logic                     s_we_o;
   logic [31:0]              s_dat_i;
   logic                     s_ack_i;
   logic                     s_err_i;
   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, s_dat_i, s_ack_i, s_err_i,
      output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o
   );
   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_cyc_i, m_stb_i, m_we_i, s_dat_i, s_ack_i, s_err_i,
      input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_cyc_o, s_stb_o, s_we_o
   );
endinterface

// File: rtl/wb_slave_arbiter.sv
// wb_slave_arbiter: round-robin Wishbone arbiter sharing one slave port, with a per-transfer watchdog
// Ports:
//   clk        tile clock, rising edge
//   rst        asynchronous active-low reset
//   bus        wb_slave_arbiter_if.slave: master lanes in, shared slave port out, responses back
//   grant_o    one-hot current grant, 0 when idle
//   timeout_o  one-cycle pulse when the watchdog aborts a hung transfer
module wb_slave_arbiter #(
   parameter int NR_MASTERS = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   wb_slave_arbiter_if.slave     bus,
   output logic [NR_MASTERS-1:0] grant_o,
   output logic                  timeout_o
);
   localparam int PW = $clog2(NR_MASTERS);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY  = 2'd1;
   localparam logic [1:0] ABORT = 2'd2;

   logic [1:0]            state;
   logic [PW-1:0]         gidx;
   logic [PW-1:0]         ptr;
   logic [PW-1:0]         nxt;
   logic [CW-1:0]         cnt;
   logic                  busy;
   logic                  cyc_g;
   logic                  stall;
   logic [NR_MASTERS-1:0] onehot;

   // Lowest requester overall covers the wrap; any requester above ptr overrides it.
   always_comb begin
      nxt = ptr;
      for (int k = NR_MASTERS - 1; k >= 0; k--)
         if (bus.m_cyc_i[k]) nxt = PW'(k);
      for (int k = NR_MASTERS - 1; k >= 0; k--)
         if (bus.m_cyc_i[k] && PW'(k) > ptr) nxt = PW'(k);
   end

   assign busy      = state == BUSY;
   assign cyc_g     = bus.m_cyc_i[gidx];
   assign onehot    = {{(NR_MASTERS-1){1'b0}}, 1'b1} << gidx;
   assign grant_o   = state == IDLE ? '0 : onehot;
   assign timeout_o = state == ABORT;

   assign bus.s_adr_o = bus.m_adr_i[{gidx, 5'd0} +: 32];
   assign bus.s_dat_o = bus.m_dat_i[{gidx, 5'd0} +: 32];
   assign bus.s_sel_o = bus.m_sel_i[{gidx, 2'd0} +: 4];
   assign bus.s_we_o  = busy & bus.m_we_i[gidx];
   assign bus.s_cyc_o = busy & cyc_g;
   assign bus.s_stb_o = busy & bus.m_stb_i[gidx];
   assign bus.m_dat_o = bus.s_dat_i;

   // Responses are gated by cyc so an ack racing the master's release is dropped.
   assign bus.m_ack_o = (busy & cyc_g & bus.s_ack_i) ? onehot : '0;
   assign bus.m_err_o = ((busy & cyc_g & bus.s_err_i) | timeout_o) ? onehot : '0;

   assign stall = bus.s_stb_o & ~bus.s_ack_i & ~bus.s_err_i;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gidx  <= '0;
         ptr   <= PW'(NR_MASTERS - 1);
         cnt   <= '0;
      end else if (state == IDLE) begin
         cnt <= '0;
         if (|bus.m_cyc_i) begin
            state <= BUSY;
            gidx  <= nxt;
         end
      end else if (busy && cyc_g) begin
         cnt <= stall ? cnt + CW'(1) : '0;
         if (stall && cnt == CW'(TIMEOUT - 1)) begin
            state <= ABORT;
            cnt   <= '0;
         end
      end else begin
         // Released cycle, finished abort, or stray encoding: hand the turn on.
         state <= IDLE;
         ptr   <= gidx;
         cnt   <= '0;
      end
   end
endmodule

// File: tb/tb_wb_slave_arbiter.sv
// tb_wb_slave_arbiter: randomized scoreboard bench for wb_slave_arbiter
// Ports: none (top-level bench); three masters share one slave model with random latency,
// slave-error and never-acking addresses plus stray acks while nobody strobes.
module tb_wb_slave_arbiter;
   localparam int NM  = 3;
   localparam int TO  = 16;
   localparam int NTX = 30;

   typedef struct packed {
      logic [1:0]  kind;
      logic [31:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NM-1:0] grant;
   logic          timeout;
   logic          mon_en = 1'b0;
   logic          force_ack = 1'b0;
   int            errors = 0;
   int            checks = 0;
   exp_t          q [NM][$];
   int            ptr_model;
   logic [NM-1:0] grant_prev;
   logic [NM-1:0] req_prev;
   logic          timeout_prev;
   int            stb_wait;

   wb_slave_arbiter_if #(.NR_MASTERS(NM)) bus ();

   wb_slave_arbiter #(.NR_MASTERS(NM), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .grant_o   (grant),
      .timeout_o (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rdat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
   endfunction

   function automatic logic [31:0] wdat(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hCAFE_F00D;
   endfunction

   // round robin: first requester after the last winner p
   function automatic int rr(input int p, input logic [NM-1:0] req);
      logic [NM-1:0] t;
      for (int i = 1; i <= NM; i++) begin
         t = req >> ((p + i) % NM);
         if (t[0]) return (p + i) % NM;
      end
      return p;
   endfunction

   task automatic check(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic run_master(input int k);
      logic [31:0] a;
      logic        got_err;
      exp_t        e;
      int          n;
      repeat (NTX) begin
         @(posedge clk); #1;
         bus.m_cyc_i[k] = 1'b1;
         for (int b = $urandom_range(1, 3); b > 0; b--) begin
            a = $urandom;
            a[31] = ($urandom_range(0, 9) == 0);
            a[30] = !a[31] && ($urandom_range(0, 9) == 0);
            bus.m_adr_i[32*k +: 32] = a;
            bus.m_dat_i[32*k +: 32] = wdat(a);
            bus.m_sel_i[4*k +: 4]   = a[3:0];
            bus.m_we_i[k]           = a[4];
            bus.m_stb_i[k]          = 1'b1;
            e.kind = a[31] ? 2'd2 : a[30] ? 2'd1 : 2'd0;
            e.data = rdat(a);
            q[k].push_back(e);
            n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!(bus.m_ack_o[k] || bus.m_err_o[k]) && n < 200);
            got_err = bus.m_err_o[k];
            if (n >= 200) begin
               checks++;
               errors++;
               $display("FAIL resp_wait m%0d: no ack/err after %0d cycles, required one", k, n);
            end
            @(posedge clk); #1;
            if (got_err || n >= 200) break;
         end
         bus.m_cyc_i[k] = 1'b0;
         bus.m_stb_i[k] = 1'b0;
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
   endtask

   // slave model: random wait, address bit 31 never answers, bit 30 answers with err
   initial begin : slave
      int w;
      w = 0;
      bus.s_ack_i = 1'b0;
      bus.s_err_i = 1'b0;
      bus.s_dat_i = '0;
      forever begin
         @(posedge clk); #2;
         if (force_ack) begin
            bus.s_ack_i = 1'b1;
            bus.s_err_i = 1'b0;
         end else if (bus.s_cyc_o && bus.s_stb_o && !bus.s_ack_i && !bus.s_err_i && !bus.s_adr_o[31]) begin
            if (w == 0) begin
               bus.s_ack_i = !bus.s_adr_o[30];
               bus.s_err_i = bus.s_adr_o[30];
               bus.s_dat_i = rdat(bus.s_adr_o);
               check(bus.s_we_o == bus.s_adr_o[4], "s_we", bus.s_we_o, bus.s_adr_o[4]);
               check(bus.s_sel_o == bus.s_adr_o[3:0], "s_sel", bus.s_sel_o, bus.s_adr_o[3:0]);
               if (bus.s_we_o) check(bus.s_dat_o == wdat(bus.s_adr_o), "s_wdat", bus.s_dat_o, wdat(bus.s_adr_o));
               w = $urandom_range(0, 3);
            end else w--;
         end else begin
            bus.s_ack_i = !bus.s_stb_o && ($urandom_range(0, 7) == 0);
            bus.s_err_i = 1'b0;
         end
      end
   end

   always @(negedge clk) begin : monitor
      logic [NM-1:0] eg;
      logic [1:0]    kind;
      exp_t          e;
      if (mon_en) begin
         if (grant_prev == '0) begin
            eg = '0;
            if (req_prev != '0) begin
               ptr_model = rr(ptr_model, req_prev);
               eg = NM'(1) << ptr_model;
            end
            check(grant == eg, "arb_grant", grant, eg);
         end else begin
            eg = (timeout_prev || (req_prev & grant_prev) == '0) ? '0 : grant_prev;
            check(grant == eg, "grant_hold", grant, eg);
         end
         check(((bus.m_ack_o | bus.m_err_o) & ~grant) == '0, "resp_outside_grant", bus.m_ack_o | bus.m_err_o, grant);
         for (int k = 0; k < NM; k++) begin
            if (bus.m_ack_o[k] || bus.m_err_o[k]) begin
               kind = !bus.m_err_o[k] ? 2'd0 : timeout ? 2'd2 : 2'd1;
               check(q[k].size() != 0, "resp_expected", kind, 32'hFFFF_FFFF);
               if (q[k].size() != 0) begin
                  e = q[k].pop_front();
                  check(kind == e.kind, "resp_kind", kind, e.kind);
                  if (kind == 2'd0) check(bus.m_dat_o == e.data, "rd_data", bus.m_dat_o, e.data);
               end
            end
         end
         if (timeout) begin
            check(stb_wait == TO, "timeout_latency", stb_wait, TO);
            check(!bus.s_cyc_o && !bus.s_stb_o, "abort_cyc", bus.s_cyc_o, 0);
            check(grant != '0 && bus.m_err_o == grant, "abort_err", bus.m_err_o, grant);
         end
         stb_wait     = (bus.s_stb_o && !bus.s_ack_i && !bus.s_err_i) ? stb_wait + 1 : 0;
         grant_prev   = grant;
         req_prev     = bus.m_cyc_i;
         timeout_prev = timeout;
      end
   end

   initial begin
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_sel_i = '0;
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      bus.m_we_i  = '0;
      #1 rst = 1'b0;
      #2;
      check(grant == '0, "rst_grant", grant, 0);
      check(!bus.s_cyc_o && !bus.s_stb_o, "rst_cyc_stb", {bus.s_cyc_o, bus.s_stb_o}, 0);
      check(!bus.s_we_o, "rst_we", bus.s_we_o, 0);
      check(bus.m_ack_o == '0, "rst_ack", bus.m_ack_o, 0);
      check(bus.m_err_o == '0, "rst_err", bus.m_err_o, 0);
      check(!timeout, "rst_timeout", timeout, 0);
      @(posedge clk);
      @(posedge clk); #1;
      rst          = 1'b1;
      ptr_model    = NM - 1;
      grant_prev   = '0;
      req_prev     = '0;
      timeout_prev = 1'b0;
      stb_wait     = 0;
      mon_en       = 1'b1;
      fork
         run_master(0);
         run_master(1);
         run_master(2);
      join
      repeat (4) @(posedge clk);
      mon_en = 1'b0;
      for (int k = 0; k < NM; k++) check(q[k].size() == 0, "queue_drained", q[k].size(), 0);
      @(posedge clk); #1;
      bus.m_adr_i[31:0] = 32'h0000_0100;
      bus.m_we_i  = '0;
      bus.m_cyc_i = 3'b001;
      bus.m_stb_i = 3'b001;
      @(posedge clk); #1;
      force_ack = 1'b1;
      #2;
      check(grant == 3'b001, "pre_rst_grant", grant, 3'b001);
      check(bus.m_ack_o == 3'b001, "pre_rst_ack", bus.m_ack_o, 3'b001);
      check(bus.s_cyc_o && bus.s_stb_o, "pre_rst_cyc", {bus.s_cyc_o, bus.s_stb_o}, 2'b11);
      rst = 1'b0;
      #1;
      check(!bus.s_cyc_o && !bus.s_stb_o, "async_rst_cyc", {bus.s_cyc_o, bus.s_stb_o}, 0);
      check(grant == '0, "async_rst_grant", grant, 0);
      check(bus.m_ack_o == '0, "async_rst_ack", bus.m_ack_o, 0);
      force_ack = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      bus.m_cyc_i = '1;
      bus.m_stb_i = '1;
      @(posedge clk); #1;
      check(grant == 3'b001, "post_rst_first", grant, 3'b001);
      bus.m_cyc_i = '0;
      bus.m_stb_i = '0;
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
